hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline. It shadows the destination and control bits of every in-flight instruction. It drives the stage-register enables, flushes and bubbles, plus the EX operand-forwarding selects and ID write-through bypass. It adds load-use stalls, taken-branch squash, memory wait-state freeze and saturating performance counters.

---
 rtl/hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_hazard_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Shadows in-flight destinations and drives stage enables, flushes, forwarding and bypass selects.
module hazard_unit #(
   parameter int          RA_W     = 4,
   parameter int unsigned ZERO_REG = 0,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_ra1,
   input  logic [RA_W-1:0]  id_ra2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [RA_W-1:0]  id_ra3,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             id_byp1,
   output logic             id_byp2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic            ex_valid_reg, ex_use1_reg, ex_use2_reg, ex_regwrite_reg, ex_memread_reg;
   logic [RA_W-1:0] ex_ra1_reg, ex_ra2_reg, ex_ra3_reg;
   logic            mem_valid_reg, mem_regwrite_reg, mem_memread_reg;
   logic [RA_W-1:0] mem_ra3_reg;
   logic            wb_valid_reg, wb_regwrite_reg;
   logic [RA_W-1:0] wb_ra3_reg;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

   // Producer/consumer address match; register 0 is excluded when hard-wired.
   function automatic logic match(input logic pv, input logic prw, input logic [RA_W-1:0] pa,
                                  input logic cuse, input logic [RA_W-1:0] ca);
      return pv && prw && cuse && (pa == ca) && !((ZERO_REG != 0) && (ca == '0));
   endfunction

   logic [RA_W-1:0] ex_src [2];
   logic [RA_W-1:0] id_src [2];
   logic            ex_use [2];
   logic            id_use [2];
   logic [1:0]      fwd_sel [2];
   logic [1:0]      byp;
   logic [1:0]      lu_hit;

   assign ex_src[0] = ex_ra1_reg;
   assign ex_src[1] = ex_ra2_reg;
   assign ex_use[0] = ex_use1_reg;
   assign ex_use[1] = ex_use2_reg;
   assign id_src[0] = id_ra1;
   assign id_src[1] = id_ra2;
   assign id_use[0] = id_use1;
   assign id_use[1] = id_use2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         // A load sitting in MEM never forwards; the load-use bubble moves it to WB first.
         assign fwd_sel[gi] =
            (rst || !ex_valid_reg) ? 2'b00 :
            match(mem_valid_reg, mem_regwrite_reg && !mem_memread_reg, mem_ra3_reg,
                  ex_use[gi], ex_src[gi]) ? 2'b01 :
            match(wb_valid_reg, wb_regwrite_reg, wb_ra3_reg, ex_use[gi], ex_src[gi]) ? 2'b10 :
            2'b00;
         assign byp[gi]    = !rst && match(wb_valid_reg, wb_regwrite_reg, wb_ra3_reg,
                                           id_use[gi], id_src[gi]);
         assign lu_hit[gi] = match(ex_valid_reg, ex_regwrite_reg, ex_ra3_reg,
                                   id_use[gi], id_src[gi]);
      end
   endgenerate

   assign fwd_a   = fwd_sel[0];
   assign fwd_b   = fwd_sel[1];
   assign id_byp1 = byp[0];
   assign id_byp2 = byp[1];

   logic mem_wait, branch, load_use, stall_ev, flush_ev;
   assign mem_wait = mem_req && !mem_ready;
   assign branch   = ex_branch_taken && ex_valid_reg;
   assign load_use = id_valid && ex_memread_reg && (|lu_hit);
   assign stall_ev = mem_wait || (load_use && !branch);
   assign flush_ev = branch && !mem_wait;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (!rst) begin
         if (mem_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
         end else if (branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg     <= 1'b0;
         ex_use1_reg      <= 1'b0;
         ex_use2_reg      <= 1'b0;
         ex_regwrite_reg  <= 1'b0;
         ex_memread_reg   <= 1'b0;
         ex_ra1_reg       <= '0;
         ex_ra2_reg       <= '0;
         ex_ra3_reg       <= '0;
         mem_valid_reg    <= 1'b0;
         mem_regwrite_reg <= 1'b0;
         mem_memread_reg  <= 1'b0;
         mem_ra3_reg      <= '0;
         wb_valid_reg     <= 1'b0;
         wb_regwrite_reg  <= 1'b0;
         wb_ra3_reg       <= '0;
         stall_cnt_reg    <= '0;
         flush_cnt_reg    <= '0;
      end else begin
         if (stall_ev && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (flush_ev && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
         if (mem_wait) begin
            wb_valid_reg <= 1'b0;
         end else begin
            wb_valid_reg     <= mem_valid_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_ra3_reg       <= mem_ra3_reg;
            mem_valid_reg    <= ex_valid_reg;
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_memread_reg  <= ex_memread_reg;
            mem_ra3_reg      <= ex_ra3_reg;
            ex_valid_reg     <= id_valid && !branch && !load_use;
            ex_ra1_reg       <= id_ra1;
            ex_ra2_reg       <= id_ra2;
            ex_use1_reg      <= id_use1;
            ex_use2_reg      <= id_use2;
            ex_ra3_reg       <= id_ra3;
            ex_regwrite_reg  <= id_regwrite;
            ex_memread_reg   <= id_memread;
         end
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: u0 (ZERO_REG=0, CNT_W=16) and u1 (ZERO_REG=1, CNT_W=2) share stimulus.
module tb_hazard_unit;
   localparam int RA_W = 4;
   localparam logic [6:0] C_N  = 7'b1111_000;
   localparam logic [6:0] C_LU = 7'b0011_010;
   localparam logic [6:0] C_BR = 7'b1111_110;
   localparam logic [6:0] C_W  = 7'b0000_001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
   logic [RA_W-1:0] id_ra1 = '0, id_ra2 = '0, id_ra3 = '0;
   logic ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

   logic pc_en0, ifid_en0, idex_en0, exmem_en0, ifid_flush0, idex_flush0, memwb_flush0;
   logic [1:0] fwd_a0, fwd_b0;
   logic id_byp10, id_byp20;
   logic [15:0] stall_cnt0, flush_cnt0;
   logic pc_en1, ifid_en1, idex_en1, exmem_en1, ifid_flush1, idex_flush1, memwb_flush1;
   logic [1:0] fwd_a1, fwd_b1;
   logic id_byp11, id_byp21;
   logic [1:0] stall_cnt1, flush_cnt1;

   hazard_unit #(.RA_W(RA_W), .ZERO_REG(0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
      .id_use1(id_use1), .id_use2(id_use2), .id_ra3(id_ra3), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_en(pc_en0), .ifid_en(ifid_en0), .idex_en(idex_en0),
      .exmem_en(exmem_en0), .ifid_flush(ifid_flush0), .idex_flush(idex_flush0),
      .memwb_flush(memwb_flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .id_byp1(id_byp10),
      .id_byp2(id_byp20), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

   hazard_unit #(.RA_W(RA_W), .ZERO_REG(1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
      .id_use1(id_use1), .id_use2(id_use2), .id_ra3(id_ra3), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_en(pc_en1), .ifid_en(ifid_en1), .idex_en(idex_en1),
      .exmem_en(exmem_en1), .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
      .memwb_flush(memwb_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .id_byp1(id_byp11),
      .id_byp2(id_byp21), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

   typedef struct {
      int         sel;
      string      tag;
      logic [6:0] ctrl;
      logic [3:0] fwd;
      logic [1:0] byp;
      int         st;
      int         fl;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [6:0] c;
      logic [3:0] f;
      logic [1:0] b;
      logic [31:0] s, l;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.sel == 0) begin
            c = {pc_en0, ifid_en0, idex_en0, exmem_en0, ifid_flush0, idex_flush0, memwb_flush0};
            f = {fwd_a0, fwd_b0};
            b = {id_byp10, id_byp20};
            s = 32'(stall_cnt0);
            l = 32'(flush_cnt0);
         end else begin
            c = {pc_en1, ifid_en1, idex_en1, exmem_en1, ifid_flush1, idex_flush1, memwb_flush1};
            f = {fwd_a1, fwd_b1};
            b = {id_byp11, id_byp21};
            s = 32'(stall_cnt1);
            l = 32'(flush_cnt1);
         end
         $display("[%0t] %s u%0d ctrl=%b fwd=%b byp=%b stall=%0d flush=%0d",
                  $time, e.tag, e.sel, c, f, b, s, l);
         check($sformatf("%s.u%0d.ctrl", e.tag, e.sel), 32'(c), 32'(e.ctrl));
         check($sformatf("%s.u%0d.fwd", e.tag, e.sel), 32'(f), 32'(e.fwd));
         check($sformatf("%s.u%0d.byp", e.tag, e.sel), 32'(b), 32'(e.byp));
         check($sformatf("%s.u%0d.stall", e.tag, e.sel), s, 32'(e.st));
         check($sformatf("%s.u%0d.flush", e.tag, e.sel), l, 32'(e.fl));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input int v, input int a1, input int a2, input int u1, input int u2,
                         input int a3, input int rw, input int mr);
      id_valid    = (v != 0);
      id_ra1      = RA_W'(a1);
      id_ra2      = RA_W'(a2);
      id_use1     = (u1 != 0);
      id_use2     = (u2 != 0);
      id_ra3      = RA_W'(a3);
      id_regwrite = (rw != 0);
      id_memread  = (mr != 0);
   endtask

   task automatic push(input int sel, input string tag, input logic [6:0] c, input logic [3:0] f,
                       input logic [1:0] b, input int st, input int fl);
      exp_t e;
      e.sel = sel; e.tag = tag; e.ctrl = c; e.fwd = f; e.byp = b; e.st = st; e.fl = fl;
      sb.push_back(e);
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // Two reset cycles with hazard-provoking inputs; the second must show reset outputs.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
      id_set(1, 5, 5, 1, 1, 5, 1, 1);
      tick();
      push(0, tag, C_N, 4'b0000, 2'b00, 0, 0);
      push(1, tag, C_N, 4'b0000, 2'b00, 0, 0);
      tick();
      rst = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0; ex_branch_taken = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // ALU chain: add r3 <- r1,r2 ; sub r4 <- r3,r3
      do_reset("rstA");
      id_set(1, 1, 2, 1, 1, 3, 1, 0); push(0, "A0", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 3, 3, 1, 1, 4, 1, 0); push(0, "A1", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(0, 0, 0, 0, 0, 0, 0, 0); push(0, "A2", C_N, 4'b0101, 2'b00, 0, 0); tick();
      push(0, "A3", C_N, 4'b0000, 2'b00, 0, 0); tick();

      // Load-use: ld r5 <- r1 ; add r6 <- r5,r1
      do_reset("rstB");
      id_set(1, 1, 0, 1, 0, 5, 1, 1); push(0, "B0", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 5, 1, 1, 1, 6, 1, 0); push(0, "B1", C_LU, 4'b0000, 2'b00, 0, 0); tick();
      push(0, "B2", C_N, 4'b0000, 2'b00, 1, 0); tick();
      id_set(0, 0, 0, 0, 0, 0, 0, 0); push(0, "B3", C_N, 4'b1000, 2'b00, 1, 0); tick();

      // Taken branch; squashed add r7 must never forward to later r7 readers
      do_reset("rstC");
      id_set(1, 1, 2, 1, 1, 0, 0, 0); push(0, "C0", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 8, 9, 1, 1, 7, 1, 0); ex_branch_taken = 1'b1;
      push(0, "C1", C_BR, 4'b0000, 2'b00, 0, 0); tick();
      ex_branch_taken = 1'b0;
      id_set(1, 7, 7, 1, 1, 10, 1, 0); push(0, "C2", C_N, 4'b0000, 2'b00, 0, 1); tick();
      id_set(1, 7, 0, 1, 0, 11, 1, 0); push(0, "C3", C_N, 4'b0000, 2'b00, 0, 1); tick();
      id_set(0, 0, 0, 0, 0, 0, 0, 0); push(0, "C4", C_N, 4'b0000, 2'b00, 0, 1); tick();

      // Three-cycle memory wait with a taken branch held in EX
      do_reset("rstD");
      id_set(1, 1, 2, 1, 1, 0, 0, 0); push(0, "D0", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 8, 9, 1, 1, 7, 1, 0);
      ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(0, $sformatf("D%0d", i + 1), C_W, 4'b0000, 2'b00, i, 0); tick();
      end
      mem_ready = 1'b1; push(0, "D4", C_BR, 4'b0000, 2'b00, 3, 0); tick();
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      id_set(1, 1, 1, 1, 1, 12, 1, 0); push(0, "D5", C_N, 4'b0000, 2'b00, 3, 1); tick();

      // Register 0: hard-wired on u1, ordinary on u0
      do_reset("rstE");
      id_set(1, 1, 0, 1, 0, 0, 1, 1);
      push(0, "E0", C_N, 4'b0000, 2'b00, 0, 0); push(1, "E0", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 0, 0, 1, 1, 3, 1, 0);
      push(0, "E1", C_LU, 4'b0000, 2'b00, 0, 0); push(1, "E1", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 1, 1, 1, 1, 2, 1, 0); push(1, "E2", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 0, 0, 1, 1, 0, 0, 0); push(1, "E3", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(0, 0, 0, 0, 0, 0, 0, 0); push(1, "E4", C_N, 4'b0000, 2'b00, 0, 0); tick();
      id_set(1, 2, 0, 1, 1, 0, 0, 0); push(1, "E5", C_N, 4'b0000, 2'b10, 0, 0); tick();

      // Five load-use stalls: u1's 2-bit counter saturates at 3
      do_reset("rstF");
      for (int k = 0; k < 5; k++) begin
         logic [3:0] fa;
         fa = (k > 0) ? 4'b1000 : 4'b0000;
         id_set(1, 1, 0, 1, 0, 5, 1, 1);
         push(0, $sformatf("F%0da", k), C_N, fa, 2'b00, k, 0);
         push(1, $sformatf("F%0da", k), C_N, fa, 2'b00, sat3(k), 0); tick();
         id_set(1, 5, 1, 1, 1, 6, 1, 0);
         push(0, $sformatf("F%0db", k), C_LU, 4'b0000, 2'b00, k, 0);
         push(1, $sformatf("F%0db", k), C_LU, 4'b0000, 2'b00, sat3(k), 0); tick();
         push(0, $sformatf("F%0dc", k), C_N, 4'b0000, 2'b00, k + 1, 0);
         push(1, $sformatf("F%0dc", k), C_N, 4'b0000, 2'b00, sat3(k + 1), 0); tick();
      end

      // Reset asserted in the middle of a stall sequence
      id_set(1, 1, 0, 1, 0, 5, 1, 1);
      push(0, "Gd", C_N, 4'b1000, 2'b00, 5, 0); push(1, "Gd", C_N, 4'b1000, 2'b00, 3, 0); tick();
      id_set(1, 5, 1, 1, 1, 6, 1, 0);
      push(0, "Ge", C_LU, 4'b0000, 2'b00, 5, 0); push(1, "Ge", C_LU, 4'b0000, 2'b00, 3, 0); tick();
      rst = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      push(0, "Gf", C_N, 4'b0000, 2'b00, 6, 0); push(1, "Gf", C_N, 4'b0000, 2'b00, 3, 0); tick();
      rst = 1'b0; mem_req = 1'b0;
      push(0, "Gg", C_N, 4'b0000, 2'b00, 0, 0); push(1, "Gg", C_N, 4'b0000, 2'b00, 0, 0); tick();

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
